// File: rtl/capture_controller.sv
// capture_controller: registers the raw channel sample, feeds latest/previous
// samples to the trigger/transition detector, and run-length encodes activity
// into a circular capture RAM with a bounded post-trigger window.
// Latency: sampleEnable -> memWrEn is 2 clk (1 sample register + 1 registered write).
// Flow: no backpressure; the RAM write port always accepts one entry per cycle.
// Ports:
//   clk, reset (sync, active-high); sampleIn/sampleEnable raw samples;
//   start/abort control; postTriggerCount latched on arm;
//   triggered/transition from the detector; latestSample/previousSample to it;
//   memWrEn/memWrAddr/memWrData RAM write port ({delta, sample});
//   triggerAddr, wrapped, state (0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE), done.
module capture_controller #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int TS_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SAMPLE_WIDTH-1:0]          sampleIn,
  input  logic                             sampleEnable,
  input  logic                             start,
  input  logic                             abort,
  input  logic [ADDR_WIDTH-1:0]            postTriggerCount,
  input  logic                             triggered,
  input  logic                             transition,
  output logic [SAMPLE_WIDTH-1:0]          latestSample,
  output logic [SAMPLE_WIDTH-1:0]          previousSample,
  output logic                             memWrEn,
  output logic [ADDR_WIDTH-1:0]            memWrAddr,
  output logic [TS_WIDTH+SAMPLE_WIDTH-1:0] memWrData,
  output logic [ADDR_WIDTH-1:0]            triggerAddr,
  output logic                             wrapped,
  output logic [1:0]                       state,
  output logic                             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [TS_WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                             state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]            latest_q, latest_d;
  logic [SAMPLE_WIDTH-1:0]            prev_q, prev_d;
  logic                               eval_q, eval_d;
  logic                               first_q, first_d;
  logic [TS_WIDTH-1:0]                cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]              rem_q, rem_d;
  logic                               wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]              wr_addr_q, wr_addr_d;
  logic [TS_WIDTH+SAMPLE_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]              trig_addr_q, trig_addr_d;
  logic                               wrapped_q, wrapped_d;
  logic                               done_q, done_d;

  logic [ADDR_WIDTH-1:0]              entry_addr;
  logic [TS_WIDTH-1:0]                delta;
  logic                               capturing;
  logic                               hit;
  logic                               arm;

  always_comb begin
    // Sample pipeline runs in every state.
    latest_d = latest_q;
    prev_d   = prev_q;
    if (sampleEnable) begin
      prev_d   = latest_q;
      latest_d = sampleIn;
    end
    eval_d = sampleEnable;

    state_d     = state_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    done_d      = done_q;

    // The address advances on the cycle the write strobe is out, so the
    // address of an entry decided now must account for a write in flight
    // (back-to-back strobes when sampleEnable is high every cycle).
    entry_addr = wr_addr_q + ADDR_WIDTH'(wr_en_q);
    wr_addr_d  = entry_addr;
    if (wr_en_q && (wr_addr_q == ADDR_MAX) && (state_q == S_ARMED)) begin
      wrapped_d = 1'b1;
    end

    // cnt holds ticks since the previous entry as of the last strobe; delta
    // is that count including the current tick, saturating.
    if (first_q) begin
      delta = '0;
    end else if (cnt_q == CNT_MAX) begin
      delta = CNT_MAX;
    end else begin
      delta = cnt_q + 1'b1;
    end

    capturing = eval_q && ((state_q == S_ARMED) || (state_q == S_TRIG));
    hit       = first_q || transition || (delta == CNT_MAX) ||
                ((state_q == S_ARMED) && triggered);
    arm       = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    if (abort) begin
      // Default wr_en_d=0 drops any write decided this cycle.
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else if (arm) begin
      state_d   = S_ARMED;
      wr_addr_d = '0;
      cnt_d     = '0;
      wrapped_d = 1'b0;
      done_d    = 1'b0;
      first_d   = 1'b1;
      // An ADDR_WIDTH-bit count never exceeds depth-1, so the trigger entry
      // plus the post-trigger entries can never lap the trigger entry.
      rem_d     = postTriggerCount;
    end else if (capturing) begin
      first_d = 1'b0;
      if (hit) begin
        wr_en_d   = 1'b1;
        wr_data_d = {delta, latest_q};
        cnt_d     = '0;
      end else begin
        cnt_d = delta;
      end

      if (state_q == S_ARMED) begin
        if (triggered) begin
          trig_addr_d = entry_addr;
          if (rem_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_TRIG;
          end
        end
      end else if (hit) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == ADDR_ONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      latest_q    <= '0;
      prev_q      <= '0;
      eval_q      <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latest_q    <= latest_d;
      prev_q      <= prev_d;
      eval_q      <= eval_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
    end
  end

  assign latestSample   = latest_q;
  assign previousSample = prev_q;
  assign memWrEn        = wr_en_q;
  assign memWrAddr      = wr_addr_q;
  assign memWrData      = wr_data_q;
  assign triggerAddr    = trig_addr_q;
  assign wrapped        = wrapped_q;
  assign state          = state_q;
  assign done           = done_q;

endmodule

// File: tb/tb_capture_controller.sv
// Testbench for capture_controller with a 4-entry RAM and 4-bit deltas.
// The detector is modelled here: transition = any channel changed,
// triggered = rising edge on ch0 while trig_en is set.
module tb_capture_controller;
  localparam int SW = 16;
  localparam int AW = 2;
  localparam int TW = 4;
  localparam int DW = TW + SW;

  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sampleIn;
  logic          sampleEnable, start, abort;
  logic [AW-1:0] postTriggerCount;
  logic          triggered, transition;
  logic [SW-1:0] latestSample, previousSample;
  logic          memWrEn;
  logic [AW-1:0] memWrAddr;
  logic [DW-1:0] memWrData;
  logic [AW-1:0] triggerAddr;
  logic          wrapped;
  logic [1:0]    state;
  logic          done;
  logic          trig_en;

  capture_controller #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .TS_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .sampleIn(sampleIn), .sampleEnable(sampleEnable),
    .start(start), .abort(abort), .postTriggerCount(postTriggerCount),
    .triggered(triggered), .transition(transition),
    .latestSample(latestSample), .previousSample(previousSample),
    .memWrEn(memWrEn), .memWrAddr(memWrAddr), .memWrData(memWrData),
    .triggerAddr(triggerAddr), .wrapped(wrapped), .state(state), .done(done)
  );

  assign transition = (latestSample != previousSample);
  assign triggered  = trig_en && !previousSample[0] && latestSample[0];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            tag;
    logic          all_zero;
    logic [1:0]    st;
    logic          wr;
    logic          dn;
    logic [AW-1:0] ta;
  } st_t;

  wr_t  wr_q[$];
  st_t  st_q[$];
  wr_t  e_wr;
  st_t  e_st;
  int   n_vec = 0;
  int   n_err = 0;
  logic fin = 1'b0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_wr(input int addr, input int dlt, input logic [SW-1:0] smp);
    wr_t w;
    w.addr = AW'(addr);
    w.data = {TW'(dlt), smp};
    wr_q.push_back(w);
  endtask

  task automatic exp_st(input int tag, input logic [1:0] st, input logic wr,
                        input logic dn, input int ta);
    st_t s;
    s.tag = tag; s.all_zero = 1'b0; s.st = st; s.wr = wr; s.dn = dn; s.ta = AW'(ta);
    st_q.push_back(s);
  endtask

  task automatic exp_zero(input int tag);
    st_t s;
    s.tag = tag; s.all_zero = 1'b1; s.st = 2'd0; s.wr = 1'b0; s.dn = 1'b0; s.ta = '0;
    st_q.push_back(s);
  endtask

  // One sample tick every three cycles: enable, evaluate, write strobe.
  task automatic sample(input logic [SW-1:0] v);
    sampleIn = v;
    sampleEnable = 1'b1;
    cyc(1);
    sampleEnable = 1'b0;
    cyc(2);
  endtask

  task automatic arm(input int ptc);
    postTriggerCount = AW'(ptc);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a status
  // check is pending; owns all counters and the summary.
  initial begin
    forever begin
      @(negedge clk);
      if (memWrEn === 1'b1) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write got addr=%0d data=%h required no write",
                   memWrAddr, memWrData);
        end else begin
          e_wr = wr_q.pop_front();
          if ({memWrAddr, memWrData} !== e_wr) begin
            n_err++;
            $display("FAIL wr_entry got addr=%0d data=%h required addr=%0d data=%h",
                     memWrAddr, memWrData, e_wr.addr, e_wr.data);
          end
        end
      end
      if (st_q.size() > 0) begin
        e_st = st_q.pop_front();
        n_vec++;
        if (e_st.all_zero) begin
          if ({latestSample, previousSample, memWrEn, memWrAddr, memWrData,
               triggerAddr, wrapped, state, done} !== '0) begin
            n_err++;
            $display("FAIL reset_zero tag=%0d got st=%0d en=%b addr=%0d data=%h ta=%0d wr=%b dn=%b lat=%h prev=%h required all 0",
                     e_st.tag, state, memWrEn, memWrAddr, memWrData, triggerAddr,
                     wrapped, done, latestSample, previousSample);
          end
        end else if ({state, wrapped, done, triggerAddr} !==
                     {e_st.st, e_st.wr, e_st.dn, e_st.ta}) begin
          n_err++;
          $display("FAIL status tag=%0d got st=%0d wr=%b dn=%b ta=%0d required st=%0d wr=%b dn=%b ta=%0d",
                   e_st.tag, state, wrapped, done, triggerAddr,
                   e_st.st, e_st.wr, e_st.dn, e_st.ta);
        end
      end
      if (fin) begin
        n_vec++;
        if (wr_q.size() != 0) begin
          n_err++;
          $display("FAIL missing_writes got %0d entries still expected required 0",
                   wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no end of run required summary before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sampleIn = '0; sampleEnable = 1'b0; start = 1'b0;
    abort = 1'b0; postTriggerCount = '0; trig_en = 1'b0;
    cyc(2);
    reset = 1'b0;
    exp_zero(1);
    cyc(1);

    // Pre-trigger history, trigger at 0x0001, two post-trigger entries.
    arm(2);
    trig_en = 1'b1;
    exp_wr(0, 0, 16'h0000); sample(16'h0000);
    sample(16'h0000);
    sample(16'h0000);
    exp_wr(1, 3, 16'h0001); sample(16'h0001);
    exp_st(2, TRIG, 1'b0, 1'b0, 1);
    exp_wr(2, 1, 16'h0003); sample(16'h0003);
    exp_wr(3, 1, 16'h0001); sample(16'h0001);
    exp_st(3, DONE, 1'b0, 1'b1, 1);
    sample(16'h0005);                        // DONE: no write
    exp_st(4, DONE, 1'b0, 1'b1, 1);

    // Abort from DONE holds triggerAddr; start+abort in IDLE stays IDLE.
    abort = 1'b1; cyc(1); abort = 1'b0;
    exp_st(5, IDLE, 1'b0, 1'b0, 1);
    cyc(1);
    start = 1'b1; abort = 1'b1; cyc(1); start = 1'b0; abort = 1'b0;
    cyc(1);
    exp_st(6, IDLE, 1'b0, 1'b0, 1);
    sample(16'h0006);                        // IDLE: no write

    // postTriggerCount=0: trigger entry is the last one.
    arm(0);
    exp_wr(0, 0, 16'h0000); sample(16'h0000);
    exp_wr(1, 1, 16'h0001); sample(16'h0001);
    exp_st(7, DONE, 1'b0, 1'b1, 1);
    sample(16'h0003);

    // Six transitions before the trigger wrap the 4-entry ring.
    arm(1);
    trig_en = 1'b0;
    exp_wr(0, 0, 16'h0000); sample(16'h0000);
    for (int v = 1; v <= 6; v++) begin
      exp_wr(v % 4, 1, SW'(v));
      sample(SW'(v));
    end
    exp_st(8, ARMED, 1'b1, 1'b0, 1);
    trig_en = 1'b1;
    exp_wr(3, 1, 16'h0007); sample(16'h0007);  // trigger+transition: one entry
    exp_st(9, TRIG, 1'b1, 1'b0, 3);
    sample(16'h0007);
    exp_wr(0, 2, 16'h0000); sample(16'h0000);
    exp_st(10, DONE, 1'b1, 1'b1, 3);

    // Constant input: delta saturates at 15 and forces an entry.
    arm(0);
    trig_en = 1'b0;
    exp_wr(0, 0, 16'h0000); sample(16'h0000);
    for (int i = 1; i <= 30; i++) begin
      if (i % 15 == 0) exp_wr(i / 15, 15, 16'h0000);
      sample(16'h0000);
    end
    exp_st(11, ARMED, 1'b0, 1'b0, 3);

    // start is ignored while ARMED (a re-arm would force a first entry).
    start = 1'b1; cyc(1); start = 1'b0;
    sample(16'h0000);
    exp_st(12, ARMED, 1'b0, 1'b0, 3);

    // Abort on the evaluation cycle drops the pending transition entry.
    sampleIn = 16'h0009; sampleEnable = 1'b1; cyc(1);
    sampleEnable = 1'b0; abort = 1'b1; cyc(1); abort = 1'b0;
    cyc(2);
    exp_st(13, IDLE, 1'b0, 1'b0, 3);

    // Reset while TRIGGERED clears everything on the next edge.
    arm(3);
    trig_en = 1'b1;
    exp_wr(0, 0, 16'h0000); sample(16'h0000);
    exp_wr(1, 1, 16'h0001); sample(16'h0001);
    exp_st(14, TRIG, 1'b0, 1'b0, 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    exp_zero(15);
    cyc(3);
    fin = 1'b1;
  end
endmodule
